// File: rtl/cpu_oci_trace_capture_if.sv
// Trace capture bus: producer side (frame payload, count, strobe) and
// consumer side (head entry, valid/ready handshake).
//   master : trace source / consumer (drives frames and rd_ready)
//   slave  : capture block (drives rd_data and rd_valid)
interface cpu_oci_trace_capture_if #(
  parameter int DCT_W = 30,
  parameter int CNT_W = 4
);
  logic [DCT_W-1:0]       dct_buffer;
  logic [CNT_W-1:0]       dct_count;
  logic                   dct_valid;
  logic [CNT_W+DCT_W-1:0] rd_data;
  logic                   rd_valid;
  logic                   rd_ready;

  modport master (
    output dct_buffer, dct_count, dct_valid, rd_ready,
    input  rd_data, rd_valid
  );

  modport slave (
    input  dct_buffer, dct_count, dct_valid, rd_ready,
    output rd_data, rd_valid
  );
endinterface

// File: rtl/cpu_oci_trace_capture.sv
// Debug-control-trace capture FIFO with end-of-test drain sequencing.
// Non-empty frames are queued as {count, buffer} while capturing; frames
// arriving to a full FIFO without a simultaneous pop are dropped and counted.
// Ports:
//   clk, reset      : single clock, synchronous active-high reset
//   trc (slave)     : frame input and head-entry valid/ready output
//   test_ending     : request end of capture (CAPTURE -> DRAIN)
//   test_has_ended  : test over; DRAIN -> DONE once the FIFO empties
//   fill_level      : current number of queued entries
//   overflow        : sticky, at least one frame dropped
//   drop_count      : saturating count of dropped frames
//   capture_done    : high in the terminal DONE state
module cpu_oci_trace_capture #(
  parameter int DCT_W  = 30,
  parameter int CNT_W  = 4,
  parameter int DEPTH  = 16,
  parameter int DROP_W = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  cpu_oci_trace_capture_if.slave   trc,
  input  logic                     test_ending,
  input  logic                     test_has_ended,
  output logic [$clog2(DEPTH):0]   fill_level,
  output logic                     overflow,
  output logic [DROP_W-1:0]        drop_count,
  output logic                     capture_done
);

  localparam int PTR_W  = $clog2(DEPTH);
  localparam int FILL_W = PTR_W + 1;
  localparam int ENT_W  = CNT_W + DCT_W;

  typedef enum logic [1:0] {CAPTURE, DRAIN, DONE} state_t;

  state_t            state, state_nxt;
  logic [ENT_W-1:0]  mem [DEPTH];
  logic [PTR_W-1:0]  wr_ptr, rd_ptr;
  logic              empty, full, push_req, push, pop, drop;

  function automatic logic [DROP_W-1:0] sat_inc(input logic [DROP_W-1:0] v);
    return (&v) ? v : v + DROP_W'(1);
  endfunction

  assign empty    = (fill_level == '0);
  assign full     = (fill_level == FILL_W'(DEPTH));
  assign pop      = !empty && trc.rd_ready;
  assign push_req = trc.dct_valid && (trc.dct_count != '0) && (state == CAPTURE);
  // A pop in the same cycle frees the slot, so a full FIFO still accepts.
  assign push     = push_req && (!full || pop);
  assign drop     = push_req && full && !pop;

  assign trc.rd_valid = !empty;
  assign trc.rd_data  = mem[rd_ptr];
  assign capture_done = (state == DONE);

  always_comb begin
    state_nxt = state;
    case (state)
      CAPTURE: if (test_ending || test_has_ended) state_nxt = DRAIN;
      // Finish once the last entry leaves, including on the popping edge.
      DRAIN:   if (test_has_ended &&
                   (empty || (fill_level == FILL_W'(1) && pop))) state_nxt = DONE;
      DONE:    state_nxt = DONE;
      default: state_nxt = CAPTURE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= CAPTURE;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fill_level <= '0;
      overflow   <= 1'b0;
      drop_count <= '0;
    end else begin
      state <= state_nxt;
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   fill_level <= fill_level + FILL_W'(1);
        2'b01:   fill_level <= fill_level - FILL_W'(1);
        default: fill_level <= fill_level;
      endcase
      if (drop) begin
        overflow   <= 1'b1;
        drop_count <= sat_inc(drop_count);
      end
    end
  end

  // Storage is data only; stale contents are unreachable after reset.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= {trc.dct_count, trc.dct_buffer};
  end

endmodule
